mem_lsu: RTL and testbench
==========================

// Module: mem_lsu
// PURPOSE
// - MEM-stage load/store unit: consumes the ALU result and operands the EX stage
//   produces, and writes back to the MEM/WB register.
// - Serialises LB/LH/LW/LBU/LHU/SB/SH/SW onto an 8-bit single-port RAM, one byte per cycle.
// - Holds the upstream pipeline with stall_req while an access is in flight.
// - Non-memory ops pass through with zero stall.
// PARAMETERS
// - ADDR_W  17  RAM byte-address width; effective address is truncated to ADDR_W bits.
// PORTS
// - clk            in   1       rising-edge clock
// - rst            in   1       reset, asynchronous, active-low
// - req_valid      in   1       EX result valid this cycle
// - req_load       in   1       op is a load
// - req_store      in   1       op is a store (req_load & req_store together = no-op)
// - req_funct3     in   3       000 B, 001 H, 010 W, 100 BU, 101 HU
// - req_result     in   32      ALU result: effective address for mem ops, wb data otherwise
// - req_wdata      in   32      store data (rs2)
// - req_wd         in   5       destination register
// - req_wreg       in   1       destination write enable
// - stall_req      out  1       hold EX and earlier stages
// - ram_a          out  ADDR_W  RAM byte address
// - ram_dout       out  8       RAM write data
// - ram_wr         out  1       RAM write strobe
// - ram_din        in   8       RAM read data; 1-cycle latency after ram_a
// - wb_wd          out  5       to MEM/WB: destination register
// - wb_wdata       out  32      to MEM/WB: data
// - wb_wreg        out  1       to MEM/WB: write enable
// - misalign       out  1       1-cycle pulse on a misaligned access (see CONFIGURATION)
// BEHAVIOUR
// - Reset (rst=0, async): state IDLE, byte counter 0; wb_*, ram_a, ram_dout = 0.
//   - ram_wr, stall_req, misalign = 0 immediately.
//   - Reset mid-access abandons it: already-written bytes stay, no writeback.
// - FSM states: IDLE, LOAD, STORE.
//   - N = bytes per op: 1 for B/BU, 2 for H/HU, 4 for W.
//   - Byte i goes to address (addr+i) mod 2^ADDR_W, little-endian; wrap at the top is legal.
// - IDLE, non-mem op (req_valid, neither or both of load/store): wb_* <= req_result/wd/wreg
//   at the next edge; stall_req=0.
// - IDLE, !req_valid: wb_wreg <= 0.
// - IDLE, mem op (cycle C0): stall_req=1 combinationally; latch addr, wdata, funct3, wd, wreg.
//   - Next state LOAD or STORE, counter i=0; wb_wreg <= 0.
// - STORE, cycles C1..CN: ram_wr=1, ram_a=addr+i, ram_dout=wdata[8i+7:8i].
//   - stall_req=1 except in CN.
//   - End of CN: wb_wreg <= 0, return to IDLE.
//   - SW occupies 5 cycles, 4 of them stalled.
// - LOAD, cycles C1..CN: ram_wr=0, ram_a=addr+(k-1) in cycle Ck.
//   - ram_din sampled at the end of Ck+1 into byte k-1.
//   - Cycle CN+1: last byte captured, extension applied, wb_* written at its end; stall_req=0.
//   - LW occupies 6 cycles, 5 of them stalled.
// - Extension: B/H sign-extend from bit 7/15; BU/HU zero-extend.
//   - Illegal funct3 on a mem op: no RAM access, 1 cycle, wb_wreg <= 0.
// - A load with wd=0 still reads RAM; wb_wreg is forwarded as latched (x0 discarded downstream).
// - Outside STORE cycles ram_wr=0 always; ram_a holds its last value.
// - While busy, req_* are ignored: upstream holds them under stall_req.
// - In the final cycle (stall_req=0) the next op is presented and accepted at C0 of the following cycle.
// CONFIGURATION
// - Macro MEM_LSU_MISALIGN_TRAP_EN.
// - Defined: H/HU with addr[0]=1, or W with addr[1:0]!=0, is detected in the C0 cycle.
//   - No RAM access; misalign=1 for that one cycle; wb_wreg <= 0 at its end.
//   - No stall in that cycle (stall_req=0); FSM stays IDLE.
// - Undefined: misaligned accesses proceed bytewise as normal; misalign tied 0.
// TESTING
// - SW 0x11223344 @0x100: RAM[0x100..0x103]=44,33,22,11; ram_wr high 4 cycles; stall_req high 4 cycles.
// - LW @0x100 after above: wb_wdata=0x11223344 and wb_wreg=1 at edge 6 after C0; stall_req high 5 cycles.
// - RAM[0x20]=0x80: LB -> 0xFFFFFF80; LBU -> 0x00000080.
// - LH @0x1FFFF, RAM[0x1FFFF]=0x34, RAM[0x00000]=0x12, macro undefined -> 0x00001234 (wrap); defined -> misalign pulse, wb_wreg=0, no RAM access.
// - ADD result 0xDEADBEEF, wd=5, back-to-back with an SB: ADD writes back next edge with no stall; SB then stalls 1 cycle.
// - Assert rst=0 during C2 of SW @0x40: ram_wr drops at once; after release the FSM is IDLE, RAM[0x42..0x43] unchanged, wb_wreg=0.

Source files
------------

// File: rtl/mem_lsu.sv
// mem_lsu -- MEM-stage load/store unit.
//
// Takes the EX-stage result and operands and produces the MEM/WB register contents.
// Loads and stores (B/H/W, BU/HU) go to an 8-bit single-port RAM one byte per
// cycle, little-endian. Byte addresses wrap modulo 2^ADDR_W. The upstream
// pipeline is held with stall_req while an access is in flight. Non-memory ops
// pass through in one cycle with no stall.
//
// Build option: define MEM_LSU_MISALIGN_TRAP_EN to trap misaligned H/HU/W
// accesses. A trapped access gets a one-cycle misalign pulse, has no RAM access
// and no writeback. When the macro is undefined, misaligned accesses run bytewise
// and misalign stays 0.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-low reset
//   req_valid/load/store     EX op valid, op is a load, op is a store
//                            (load and store together = no-op)
//   req_funct3               000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_result               effective address (mem ops) or writeback data
//   req_wdata                store data (rs2)
//   req_wd, req_wreg         destination register and its write enable
//   stall_req                hold EX and earlier stages
//   ram_a/ram_dout/ram_wr    RAM address, write data, write strobe
//   ram_din                  RAM read data, valid one cycle after ram_a
//   wb_wd/wb_wdata/wb_wreg   MEM/WB register outputs
//   misalign                 one-cycle pulse on a trapped misaligned access
module mem_lsu #(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_load,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_result,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_wd,
    input  logic              req_wreg,
    output logic              stall_req,
    output logic [ADDR_W-1:0] ram_a,
    output logic [7:0]        ram_dout,
    output logic              ram_wr,
    input  logic [7:0]        ram_din,
    output logic [4:0]        wb_wd,
    output logic [31:0]       wb_wdata,
    output logic              wb_wreg,
    output logic              misalign
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_STORE = 2'd2
    } state_t;

    // Bytes moved by an access; 0 marks an illegal funct3.
    function automatic logic [2:0] op_bytes(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: op_bytes = 3'd1;
            3'b001, 3'b101: op_bytes = 3'd2;
            3'b010:         op_bytes = 3'd4;
            default:        op_bytes = 3'd0;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000:  load_extend = {{24{d[7]}}, d[7:0]};
            3'b001:  load_extend = {{16{d[15]}}, d[15:0]};
            3'b100:  load_extend = {24'h000000, d[7:0]};
            3'b101:  load_extend = {16'h0000, d[15:0]};
            default: load_extend = d;
        endcase
    endfunction

    function automatic logic [7:0] byte_of(input logic [31:0] d, input logic [1:0] idx);
        byte_of = d[{idx, 3'b000} +: 8];
    endfunction

    state_t            state_r;
    state_t            state_next_s;
    logic [2:0]        cnt_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wdata_r;
    logic [2:0]        funct3_r;
    logic [4:0]        wd_r;
    logic              wreg_r;
    logic [31:0]       ldata_r;

    logic              is_mem_s;
    logic [2:0]        req_bytes_s;
    logic              misalign_s;
    logic              start_s;
    logic [2:0]        n_r_s;
    logic [2:0]        cnt_inc_s;
    logic              store_last_s;
    logic              load_last_s;
    logic [1:0]        ld_idx_s;
    logic [31:0]       load_word_s;

    assign is_mem_s     = req_valid && (req_load != req_store);
    assign req_bytes_s  = op_bytes(req_funct3);
    assign n_r_s        = op_bytes(funct3_r);
    assign cnt_inc_s    = cnt_r + 3'd1;
    assign store_last_s = (cnt_r == (n_r_s - 3'd1));
    assign load_last_s  = (cnt_r == n_r_s);
    // In LOAD, the byte landing on ram_din belongs to the address issued one cycle earlier.
    assign ld_idx_s     = 2'(cnt_r - 3'd1);

`ifdef MEM_LSU_MISALIGN_TRAP_EN
    assign misalign_s = is_mem_s &&
                        (((req_bytes_s == 3'd2) && req_result[0]) ||
                         ((req_bytes_s == 3'd4) && (req_result[1:0] != 2'b00)));
`else
    assign misalign_s = 1'b0;
`endif

    // An access starts only for a legal, non-trapped memory op seen in IDLE.
    assign start_s = (state_r == ST_IDLE) && is_mem_s && (req_bytes_s != 3'd0) && !misalign_s;

    // Load assembly: merge the byte arriving on ram_din into the partial word.
    always_comb begin
        load_word_s = ldata_r;
        if ((state_r == ST_LOAD) && (cnt_r != 3'd0)) begin
            load_word_s[{ld_idx_s, 3'b000} +: 8] = ram_din;
        end else begin
            load_word_s = ldata_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    if (req_load) begin
                        state_next_s = ST_LOAD;
                    end else begin
                        state_next_s = ST_STORE;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (load_last_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_STORE: begin
                if (store_last_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_STORE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM outputs; forced low while reset is asserted so they drop immediately.
    always_comb begin
        stall_req = 1'b0;
        misalign  = 1'b0;
        if (!rst) begin
            stall_req = 1'b0;
            misalign  = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    stall_req = start_s;
                    misalign  = misalign_s;
                end
                ST_LOAD:  stall_req = !load_last_s;
                ST_STORE: stall_req = !store_last_s;
                default:  stall_req = 1'b0;
            endcase
        end
    end

    // Datapath: operand latch, RAM port sequencing, load assembly and MEM/WB register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r    <= 3'd0;
            addr_r   <= '0;
            wdata_r  <= 32'h0000_0000;
            funct3_r <= 3'b000;
            wd_r     <= 5'd0;
            wreg_r   <= 1'b0;
            ldata_r  <= 32'h0000_0000;
            ram_a    <= '0;
            ram_dout <= 8'h00;
            ram_wr   <= 1'b0;
            wb_wd    <= 5'd0;
            wb_wdata <= 32'h0000_0000;
            wb_wreg  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ram_wr <= start_s && req_store;
                    if (!req_valid) begin
                        wb_wreg <= 1'b0;
                    end else if (!is_mem_s) begin
                        wb_wd    <= req_wd;
                        wb_wdata <= req_result;
                        wb_wreg  <= req_wreg;
                    end else begin
                        // Memory ops never write back at C0; trapped/illegal ones end here.
                        wb_wreg <= 1'b0;
                        if (start_s) begin
                            addr_r   <= req_result[ADDR_W-1:0];
                            wdata_r  <= req_wdata;
                            funct3_r <= req_funct3;
                            wd_r     <= req_wd;
                            wreg_r   <= req_wreg;
                            cnt_r    <= 3'd0;
                            ldata_r  <= 32'h0000_0000;
                            ram_a    <= req_result[ADDR_W-1:0];
                            ram_dout <= req_wdata[7:0];
                        end
                    end
                end
                ST_STORE: begin
                    if (store_last_s) begin
                        ram_wr  <= 1'b0;
                        wb_wreg <= 1'b0;
                    end else begin
                        cnt_r    <= cnt_inc_s;
                        ram_a    <= addr_r + ADDR_W'(cnt_inc_s);
                        ram_dout <= byte_of(wdata_r, cnt_inc_s[1:0]);
                    end
                end
                ST_LOAD: begin
                    ldata_r <= load_word_s;
                    if (load_last_s) begin
                        wb_wd    <= wd_r;
                        wb_wdata <= load_extend(funct3_r, load_word_s);
                        wb_wreg  <= wreg_r;
                    end else begin
                        cnt_r <= cnt_inc_s;
                        // Address stops advancing after the last byte has been issued.
                        if (cnt_inc_s < n_r_s) begin
                            ram_a <= addr_r + ADDR_W'(cnt_inc_s);
                        end
                    end
                end
                default: begin
                    ram_wr  <= 1'b0;
                    wb_wreg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu -- randomized self-checking bench for mem_lsu.
// A byte-array RAM with one-cycle read latency is attached to the DUT. A separate
// reference byte array describes what memory should hold. Each op's expected
// stall cycles, RAM write cycles, misalign pulses and writeback are derived from
// the op's architectural meaning.
module tb_mem_lsu;
    localparam int ADDR_W = 17;
    localparam int RAM_SZ = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_load, req_store, req_wreg;
    logic [2:0]        req_funct3;
    logic [31:0]       req_result, req_wdata;
    logic [4:0]        req_wd;
    logic              stall_req, ram_wr, wb_wreg, misalign;
    logic [ADDR_W-1:0] ram_a;
    logic [7:0]        ram_dout, ram_din;
    logic [4:0]        wb_wd;
    logic [31:0]       wb_wdata;

    logic              poke_en = 1'b0;
    logic [ADDR_W-1:0] poke_a = '0;
    logic [7:0]        poke_d = 8'h00;

    logic [7:0] ram     [0:RAM_SZ-1];
    logic [7:0] ref_mem [0:RAM_SZ-1];

    int n_checks = 0;
    int n_pass   = 0;

    mem_lsu #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_load(req_load), .req_store(req_store),
        .req_funct3(req_funct3), .req_result(req_result), .req_wdata(req_wdata),
        .req_wd(req_wd), .req_wreg(req_wreg),
        .stall_req(stall_req), .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr),
        .ram_din(ram_din),
        .wb_wd(wb_wd), .wb_wdata(wb_wdata), .wb_wreg(wb_wreg), .misalign(misalign)
    );

    always #5 clk = ~clk;

    // Single-port byte RAM, registered read; the bench preloads through poke_*.
    always @(posedge clk) begin
        if (poke_en) ram[poke_a] <= poke_d;
        else if (ram_wr) ram[ram_a] <= ram_dout;
        ram_din <= ram[ram_a];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic bit traps(input int nb, input int a);
        bit trap_en;
`ifdef MEM_LSU_MISALIGN_TRAP_EN
        trap_en = 1'b1;
`else
        trap_en = 1'b0;
`endif
        return trap_en && ((nb == 2 && (a % 2) != 0) || (nb == 4 && (a % 4) != 0));
    endfunction

    task automatic poke(input int a, input logic [7:0] d);
        poke_en = 1'b1; poke_a = ADDR_W'(a); poke_d = d;
        ref_mem[a] = d;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    // Present one op at C0, run it to its non-stalled final cycle, check the outcome.
    task automatic run_op(input string tag, input logic v, input logic ld, input logic st,
                          input logic [2:0] f3, input logic [31:0] res, input logic [31:0] wdat,
                          input logic [4:0] wd, input logic wr);
        int nb, a, exp_stall, exp_wr, exp_mis, stalls, writes, mis;
        bit is_mem, trap, runs, done, s;
        logic [31:0] exp_data;
        longint v64;
        is_mem = v && (ld != st);
        nb = nbytes(f3);
        a = int'(res[ADDR_W-1:0]);
        trap = is_mem && nb != 0 && traps(nb, a);
        runs = is_mem && nb != 0 && !trap;
        exp_mis = trap ? 1 : 0;
        exp_stall = 0; exp_wr = 0;
        if (runs && ld) exp_stall = nb + 1;
        if (runs && st) begin exp_stall = nb; exp_wr = nb; end
        exp_data = res;
        if (runs && ld) begin
            v64 = 0;
            for (int i = 0; i < nb; i++) v64 += longint'(ref_mem[(a + i) % RAM_SZ]) << (8 * i);
            if (!f3[2] && nb < 4 && v64 >= (longint'(1) << (8 * nb - 1))) v64 -= longint'(1) << (8 * nb);
            exp_data = v64[31:0];
        end

        req_valid = v; req_load = ld; req_store = st; req_funct3 = f3;
        req_result = res; req_wdata = wdat; req_wd = wd; req_wreg = wr;
        stalls = 0; writes = 0; mis = 0; done = 1'b0;
        for (int c = 0; c < 16 && !done; c++) begin
            @(negedge clk);
            s = stall_req;
            if (stall_req) stalls++;
            if (ram_wr) writes++;
            if (misalign) mis++;
            @(posedge clk); #1;
            if (!s) done = 1'b1;
        end
        req_valid = 1'b0;
        if (!done) check_eq($sformatf("%s.timeout", tag), 32'd0, 32'd1);

        check_eq($sformatf("%s.stall_cycles", tag), stalls, exp_stall);
        check_eq($sformatf("%s.write_cycles", tag), writes, exp_wr);
        check_eq($sformatf("%s.misalign", tag), mis, exp_mis);
        if ((v && !is_mem) || (runs && ld)) begin
            check_eq($sformatf("%s.wb_wreg", tag), {31'd0, wb_wreg}, {31'd0, wr});
            check_eq($sformatf("%s.wb_wd", tag), {27'd0, wb_wd}, {27'd0, wd});
            check_eq($sformatf("%s.wb_wdata", tag), wb_wdata, exp_data);
        end else begin
            check_eq($sformatf("%s.wb_wreg", tag), {31'd0, wb_wreg}, 32'd0);
        end
        if (runs && st) begin
            for (int i = 0; i < nb; i++) begin
                ref_mem[(a + i) % RAM_SZ] = wdat[8 * i +: 8];
                check_eq($sformatf("%s.ram[%0h]", tag, (a + i) % RAM_SZ),
                         {24'd0, ram[(a + i) % RAM_SZ]}, {24'd0, ref_mem[(a + i) % RAM_SZ]});
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        // A store is presented during reset: the combinational outputs must stay low.
        req_valid = 1'b1; req_load = 1'b0; req_store = 1'b1; req_funct3 = 3'b010;
        req_result = 32'h0000_0100; req_wdata = 32'h1234_5678; req_wd = 5'd3; req_wreg = 1'b1;
        #12;
        check_eq("rst.stall_req", {31'd0, stall_req}, 32'd0);
        check_eq("rst.ram_wr", {31'd0, ram_wr}, 32'd0);
        check_eq("rst.misalign", {31'd0, misalign}, 32'd0);
        check_eq("rst.ram_a", {15'd0, ram_a}, 32'd0);
        check_eq("rst.ram_dout", {24'd0, ram_dout}, 32'd0);
        check_eq("rst.wb_wd", {27'd0, wb_wd}, 32'd0);
        check_eq("rst.wb_wdata", wb_wdata, 32'd0);
        check_eq("rst.wb_wreg", {31'd0, wb_wreg}, 32'd0);
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 16'h50; i++) poke(i, 8'($urandom));
        for (int i = 17'h1FFF0; i < RAM_SZ; i++) poke(i, 8'($urandom));
        for (int i = 16'h100; i < 16'h104; i++) poke(i, 8'($urandom));
        poke(16'h20, 8'h80);
        poke(17'h1FFFF, 8'h34);
        poke(0, 8'h12);

        run_op("sw_100", 1, 0, 1, 3'b010, 32'h0000_0100, 32'h1122_3344, 5'd0, 1'b0);
        run_op("lw_100", 1, 1, 0, 3'b010, 32'h0000_0100, 32'h0, 5'd7, 1'b1);
        check_eq("lw_100.value", wb_wdata, 32'h1122_3344);
        run_op("lb_20", 1, 1, 0, 3'b000, 32'h0000_0020, 32'h0, 5'd8, 1'b1);
        check_eq("lb_20.value", wb_wdata, 32'hFFFF_FF80);
        run_op("lbu_20", 1, 1, 0, 3'b100, 32'h0000_0020, 32'h0, 5'd9, 1'b1);
        check_eq("lbu_20.value", wb_wdata, 32'h0000_0080);
        run_op("lh_wrap", 1, 1, 0, 3'b001, 32'h0001_FFFF, 32'h0, 5'd10, 1'b1);
        run_op("add", 1, 0, 0, 3'b000, 32'hDEAD_BEEF, 32'h0, 5'd5, 1'b1);
        run_op("sb_after_add", 1, 0, 1, 3'b000, 32'h0000_0030, 32'h0000_00A5, 5'd0, 1'b0);
        run_op("nop_invalid", 0, 1, 0, 3'b010, 32'h0000_0000, 32'h0, 5'd1, 1'b1);
        run_op("ld_illegal_f3", 1, 1, 0, 3'b011, 32'h0000_0004, 32'h0, 5'd2, 1'b1);
        run_op("ld_and_st", 1, 1, 1, 3'b010, 32'h0000_1234, 32'h0, 5'd4, 1'b1);

        // Reset during C2 of a word store: only the first byte may land.
        req_valid = 1'b1; req_load = 1'b0; req_store = 1'b1; req_funct3 = 3'b010;
        req_result = 32'h0000_0040; req_wdata = 32'hCAFE_F00D; req_wd = 5'd0; req_wreg = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        #1;
        check_eq("rstmid.ram_wr", {31'd0, ram_wr}, 32'd0);
        check_eq("rstmid.stall_req", {31'd0, stall_req}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        ref_mem[16'h40] = 8'h0D;
        check_eq("rstmid.ram40", {24'd0, ram[16'h40]}, {24'd0, ref_mem[16'h40]});
        check_eq("rstmid.ram41", {24'd0, ram[16'h41]}, {24'd0, ref_mem[16'h41]});
        check_eq("rstmid.ram42", {24'd0, ram[16'h42]}, {24'd0, ref_mem[16'h42]});
        check_eq("rstmid.ram43", {24'd0, ram[16'h43]}, {24'd0, ref_mem[16'h43]});
        check_eq("rstmid.wb_wreg", {31'd0, wb_wreg}, 32'd0);
        run_op("after_rst_alu", 1, 0, 0, 3'b010, 32'h0BAD_F00D, 32'h0, 5'd12, 1'b1);

        for (int k = 0; k < 80; k++) begin
            logic [31:0] r, wdat;
            logic [2:0]  f3;
            logic [4:0]  wd;
            logic        wr;
            int          kind;
            r = $urandom; wdat = $urandom;
            if ($urandom_range(0, 3) == 0) r[16:0] = 17'h1FFFC + 17'($urandom_range(0, 3));
            else r[16:0] = 17'($urandom_range(0, 63));
            f3 = 3'($urandom_range(0, 7));
            wd = 5'($urandom_range(0, 31));
            wr = 1'($urandom_range(0, 1));
            kind = $urandom_range(0, 9);
            if (kind == 0)      run_op($sformatf("rnd%0d.inv", k), 0, 1, 0, f3, r, wdat, wd, wr);
            else if (kind == 1) run_op($sformatf("rnd%0d.alu", k), 1, 0, 0, f3, r, wdat, wd, wr);
            else if (kind == 2) run_op($sformatf("rnd%0d.both", k), 1, 1, 1, f3, r, wdat, wd, wr);
            else if (kind < 7)  run_op($sformatf("rnd%0d.ld", k), 1, 1, 0, f3, r, wdat, wd, wr);
            else                run_op($sformatf("rnd%0d.st", k), 1, 0, 1, f3, r, wdat, wd, wr);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
